// File: rtl/mem_bus_arbiter.sv
// Round-robin arbiter sharing one AXI4-lite master port between instruction fetch
// and data load/store, with one transaction outstanding and req/done handshakes.
module mem_bus_arbiter #(
  parameter int          ADDR_W    = 32,
  parameter logic [2:0]  INST_PROT = 3'b101,
  parameter logic [2:0]  DATA_PROT = 3'b000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_done,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [31:0]       d_wdata,
  input  logic [3:0]        d_wstrb,
  output logic              d_done,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err,
  output logic              awvalid,
  input  logic              awready,
  output logic [ADDR_W-1:0] awaddr,
  output logic [2:0]        awprot,
  output logic              wvalid,
  input  logic              wready,
  output logic [31:0]       wdata,
  output logic [3:0]        wstrb,
  input  logic              bvalid,
  output logic              bready,
  input  logic [1:0]        bresp,
  output logic              arvalid,
  input  logic              arready,
  output logic [ADDR_W-1:0] araddr,
  output logic [2:0]        arprot,
  input  logic              rvalid,
  output logic              rready,
  input  logic [31:0]       rdata,
  input  logic [1:0]        rresp
);

  typedef enum logic [1:0] {S_IDLE, S_READ, S_WRITE, S_WRESP} state_t;

  state_t              state_q, state_d;
  logic                last_data_q, last_data_d;
  logic                active_data_q, active_data_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [31:0]         wdata_q, wdata_d;
  logic [3:0]          wstrb_q, wstrb_d;
  logic [2:0]          prot_q, prot_d;
  logic                arvalid_q, arvalid_d;
  logic                rready_q, rready_d;
  logic                awvalid_q, awvalid_d;
  logic                wvalid_q, wvalid_d;
  logic                bready_q, bready_d;
  logic                i_done_q, i_done_d;
  logic                d_done_q, d_done_d;
  logic [31:0]         rsp_rdata_q, rsp_rdata_d;
  logic                rsp_err_q, rsp_err_d;
  logic                grant_data;
  logic                aw_taken;
  logic                w_taken;

  // Data wins a tie only when the previous grant went to the fetch side.
  assign grant_data = d_req && (!i_req || !last_data_q);
  assign aw_taken   = !awvalid_q || awready;
  assign w_taken    = !wvalid_q || wready;

  always_comb begin
    state_d       = state_q;
    last_data_d   = last_data_q;
    active_data_d = active_data_q;
    addr_d        = addr_q;
    wdata_d       = wdata_q;
    wstrb_d       = wstrb_q;
    prot_d        = prot_q;
    arvalid_d     = arvalid_q;
    rready_d      = rready_q;
    awvalid_d     = awvalid_q;
    wvalid_d      = wvalid_q;
    bready_d      = bready_q;
    i_done_d      = 1'b0;
    d_done_d      = 1'b0;
    rsp_rdata_d   = rsp_rdata_q;
    rsp_err_d     = rsp_err_q;

    unique case (state_q)
      S_IDLE: begin
        // The cycle carrying a done pulse never grants, so a held req restarts next cycle.
        if ((i_req || d_req) && !i_done_q && !d_done_q) begin
          active_data_d = grant_data;
          last_data_d   = grant_data;
          addr_d        = grant_data ? d_addr : i_addr;
          if (grant_data && d_we) begin
            wdata_d   = d_wdata;
            wstrb_d   = d_wstrb;
            prot_d    = DATA_PROT;
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
            state_d   = S_WRITE;
          end else begin
            prot_d    = grant_data ? DATA_PROT : INST_PROT;
            arvalid_d = 1'b1;
            rready_d  = 1'b1;
            state_d   = S_READ;
          end
        end
      end
      S_READ: begin
        if (arvalid_q && arready) arvalid_d = 1'b0;
        if (rready_q && rvalid) begin
          arvalid_d   = 1'b0;
          rready_d    = 1'b0;
          rsp_rdata_d = rdata;
          rsp_err_d   = rresp[1];
          i_done_d    = !active_data_q;
          d_done_d    = active_data_q;
          state_d     = S_IDLE;
        end
      end
      S_WRITE: begin
        if (awvalid_q && awready) awvalid_d = 1'b0;
        if (wvalid_q && wready) wvalid_d = 1'b0;
        if (aw_taken && w_taken) begin
          bready_d = 1'b1;
          state_d  = S_WRESP;
        end
      end
      S_WRESP: begin
        if (bvalid) begin
          bready_d    = 1'b0;
          rsp_rdata_d = 32'h0;
          rsp_err_d   = bresp[1];
          d_done_d    = 1'b1;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= S_IDLE;
      last_data_q   <= 1'b0;
      active_data_q <= 1'b0;
      addr_q        <= '0;
      wdata_q       <= 32'h0;
      wstrb_q       <= 4'h0;
      prot_q        <= 3'b000;
      arvalid_q     <= 1'b0;
      rready_q      <= 1'b0;
      awvalid_q     <= 1'b0;
      wvalid_q      <= 1'b0;
      bready_q      <= 1'b0;
      i_done_q      <= 1'b0;
      d_done_q      <= 1'b0;
      rsp_rdata_q   <= 32'h0;
      rsp_err_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      last_data_q   <= last_data_d;
      active_data_q <= active_data_d;
      addr_q        <= addr_d;
      wdata_q       <= wdata_d;
      wstrb_q       <= wstrb_d;
      prot_q        <= prot_d;
      arvalid_q     <= arvalid_d;
      rready_q      <= rready_d;
      awvalid_q     <= awvalid_d;
      wvalid_q      <= wvalid_d;
      bready_q      <= bready_d;
      i_done_q      <= i_done_d;
      d_done_q      <= d_done_d;
      rsp_rdata_q   <= rsp_rdata_d;
      rsp_err_q     <= rsp_err_d;
    end
  end

  assign i_done    = i_done_q;
  assign d_done    = d_done_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;
  assign awvalid   = awvalid_q;
  assign awaddr    = addr_q;
  assign awprot    = DATA_PROT;
  assign wvalid    = wvalid_q;
  assign wdata     = wdata_q;
  assign wstrb     = wstrb_q;
  assign bready    = bready_q;
  assign arvalid   = arvalid_q;
  assign araddr    = addr_q;
  assign arprot    = prot_q;
  assign rready    = rready_q;

endmodule
